// File: rtl/dino_pkg.sv
// Shared obstacle definitions: type codes, sky/ground rows, sprite sizes and atlas layout.
package dino_pkg;

  typedef enum logic [2:0] {
    LOW_BIRD     = 3'd0,
    HIGH_BIRD    = 3'd1,
    SMALL_CACTUS = 3'd2,
    MANY_CACTUS  = 3'd3,
    BIG_CACTUS   = 3'd4,
    NOTHING      = 3'd5
  } obstacle_t;

  localparam int ATLAS_W = 14;

  localparam logic [9:0] GROUND   = 10'd147;
  localparam logic [9:0] LOW_SKY  = 10'd140;
  localparam logic [9:0] HIGH_SKY = 10'd100;

  localparam logic [6:0] BIRD_W  = 7'd44;
  localparam logic [5:0] BIRD_H  = 6'd33;
  localparam logic [6:0] SMALL_W = 7'd19;
  localparam logic [5:0] SMALL_H = 6'd36;
  localparam logic [6:0] MANY_W  = 7'd77;
  localparam logic [5:0] MANY_H  = 6'd49;
  localparam logic [6:0] BIG_W   = 7'd27;
  localparam logic [5:0] BIG_H   = 6'd50;

  localparam logic [ATLAS_W-1:0] BIRD0_BASE = 14'd0;
  localparam logic [ATLAS_W-1:0] BIRD1_BASE = 14'd1452;
  localparam logic [ATLAS_W-1:0] SMALL_BASE = 14'd2904;
  localparam logic [ATLAS_W-1:0] MANY_BASE  = 14'd3588;
  localparam logic [ATLAS_W-1:0] BIG_BASE   = 14'd7361;

  function automatic logic drawable(input logic [2:0] kind);
    return kind <= BIG_CACTUS;
  endfunction

  function automatic logic [6:0] sprite_width(input logic [2:0] kind);
    case (kind)
      LOW_BIRD, HIGH_BIRD: return BIRD_W;
      SMALL_CACTUS:        return SMALL_W;
      MANY_CACTUS:         return MANY_W;
      BIG_CACTUS:          return BIG_W;
      default:             return 7'd0;
    endcase
  endfunction

  function automatic logic [5:0] sprite_height(input logic [2:0] kind);
    case (kind)
      LOW_BIRD, HIGH_BIRD: return BIRD_H;
      SMALL_CACTUS:        return SMALL_H;
      MANY_CACTUS:         return MANY_H;
      BIG_CACTUS:          return BIG_H;
      default:             return 6'd0;
    endcase
  endfunction

  function automatic logic [9:0] sprite_bottom(input logic [2:0] kind);
    case (kind)
      LOW_BIRD:  return LOW_SKY;
      HIGH_BIRD: return HIGH_SKY;
      default:   return GROUND;
    endcase
  endfunction

  function automatic logic [ATLAS_W-1:0] sprite_base(input logic [2:0] kind, input logic flap);
    case (kind)
      LOW_BIRD, HIGH_BIRD: return flap ? BIRD1_BASE : BIRD0_BASE;
      SMALL_CACTUS:        return SMALL_BASE;
      MANY_CACTUS:         return MANY_BASE;
      BIG_CACTUS:          return BIG_BASE;
      default:             return '0;
    endcase
  endfunction

endpackage

// File: rtl/sprite_box_hit.sv
// Box test for one obstacle slot against the current scan position, plus sprite row/column.
module sprite_box_hit
  import dino_pkg::*;
(
  input  logic       en,
  input  logic [2:0] kind,
  input  logic [8:0] pos,
  input  logic [9:0] h,
  input  logic [9:0] v,
  output logic       hit,
  output logic [5:0] row,
  output logic [6:0] col
);

  logic [6:0]  wid;
  logic [9:0]  top;
  logic [9:0]  bottom;
  logic [10:0] left;

  // Left edge clamps at 0; column stays pos-relative so a clipped sprite shows its right part.
  always_comb begin
    wid    = sprite_width(kind);
    bottom = sprite_bottom(kind);
    top    = bottom - 10'(sprite_height(kind));
    left   = ({2'b00, pos} < {4'b0000, wid}) ? 11'd0 : ({2'b00, pos} - {4'b0000, wid});
    hit    = en && drawable(kind)
             && ({1'b0, h} >= left) && ({1'b0, h} < {2'b00, pos})
             && (v >= top) && (v < bottom);
    row    = 6'(v - top);
    col    = 7'({1'b0, h} + {4'b0000, wid} - {2'b00, pos});
  end

endmodule

// File: rtl/danger_sprite_engine.sv
// Obstacle renderer: per-frame slot shadows, priority select, atlas addressing,
// bird flap animation and a sticky dino collision flag.
module danger_sprite_engine
  import dino_pkg::*;
#(
  parameter int N_SLOTS     = 3,
  parameter int ADDR_W      = 14,
  parameter int FLAP_FRAMES = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_en,
  input  logic [9:0]             h_cnt,
  input  logic [9:0]             v_cnt,
  input  logic                   frame_start,
  input  logic [N_SLOTS-1:0]     slot_en,
  input  logic [3*N_SLOTS-1:0]   slot_type,
  input  logic [9*N_SLOTS-1:0]   slot_pos,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [11:0]            rom_data,
  input  logic                   dino_opaque,
  input  logic                   collide_clr,
  output logic [11:0]            pixel,
  output logic                   pixel_hit,
  output logic                   collide
);

  localparam int CNT_W = (FLAP_FRAMES > 1) ? $clog2(FLAP_FRAMES) : 1;

  logic [N_SLOTS-1:0]   sh_en;
  logic [3*N_SLOTS-1:0] sh_type;
  logic [9*N_SLOTS-1:0] sh_pos;
  logic [CNT_W-1:0]     flap_cnt;
  logic                 flap;

  logic [N_SLOTS-1:0] hits;
  logic [5:0]         rows [N_SLOTS];
  logic [6:0]         cols [N_SLOTS];

  logic              sel_hit;
  logic [2:0]        sel_kind;
  logic [5:0]        sel_row;
  logic [6:0]        sel_col;
  logic [ADDR_W-1:0] next_addr;

  logic hit_a, valid_a, hit_b, valid_b;

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    sprite_box_hit u_box (
      .en   (sh_en[i]),
      .kind (sh_type[3*i +: 3]),
      .pos  (sh_pos[9*i +: 9]),
      .h    (h_cnt),
      .v    (v_cnt),
      .hit  (hits[i]),
      .row  (rows[i]),
      .col  (cols[i])
    );
  end

  // Slots are latched once per frame so obstacles never tear mid-frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_en    <= '0;
      sh_type  <= '0;
      sh_pos   <= '0;
      flap_cnt <= '0;
      flap     <= 1'b0;
    end else if (frame_start) begin
      sh_en   <= slot_en;
      sh_type <= slot_type;
      sh_pos  <= slot_pos;
      if (flap_cnt == CNT_W'(FLAP_FRAMES - 1)) begin
        flap_cnt <= '0;
        flap     <= ~flap;
      end else begin
        flap_cnt <= flap_cnt + 1'b1;
      end
    end
  end

  // Walk from the back so the lowest-index hitting slot wins the single ROM read.
  always_comb begin
    sel_hit  = 1'b0;
    sel_kind = NOTHING;
    sel_row  = '0;
    sel_col  = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (hits[i]) begin
        sel_hit  = 1'b1;
        sel_kind = sh_type[3*i +: 3];
        sel_row  = rows[i];
        sel_col  = cols[i];
      end
    end
    next_addr = ADDR_W'(sprite_base(sel_kind, flap))
              + ADDR_W'(sel_row) * ADDR_W'(sprite_width(sel_kind))
              + ADDR_W'(sel_col);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr  <= '0;
      hit_a     <= 1'b0;
      valid_a   <= 1'b0;
      hit_b     <= 1'b0;
      valid_b   <= 1'b0;
      pixel     <= 12'hFFF;
      pixel_hit <= 1'b0;
    end else if (pix_en) begin
      rom_addr  <= next_addr;
      hit_a     <= sel_hit;
      valid_a   <= 1'b1;
      hit_b     <= hit_a;
      valid_b   <= valid_a;
      pixel     <= (valid_b && hit_b) ? rom_data : 12'hFFF;
      pixel_hit <= valid_b && hit_b;
    end
  end

  // Judged on the pixel being emitted this tick; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      collide <= 1'b0;
    end else if (pix_en && valid_b && hit_b && (rom_data != 12'hFFF) && dino_opaque) begin
      collide <= 1'b1;
    end else if (collide_clr) begin
      collide <= 1'b0;
    end
  end

endmodule

// File: doc/danger_sprite_engine.md
# danger_sprite_engine

Parametrised obstacle renderer for the VGA path. It draws up to N_SLOTS cacti and birds from one shared sprite-atlas ROM and flaps the bird sprite on a frame counter. Slot descriptors are latched once per frame, so obstacles never tear mid-frame. The block also flags collisions between obstacle pixels and the dino.

## Interface
- N_SLOTS, 3: number of obstacle slots.
- ADDR_W, 14: atlas ROM address width.
- FLAP_FRAMES, 12: frames per bird animation phase.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- pix_en  in  1  pixel-rate enable; the whole pipeline advances only when it is high.
- h_cnt, v_cnt  in  10 each  current scan position.
- frame_start  in  1  one-clk pulse at vblank start.
- slot_en  in  N_SLOTS  per-slot enable.
- slot_type  in  3*N_SLOTS  per-slot type: 0 LOW_BIRD, 1 HIGH_BIRD, 2 SMALL_CACTUS, 3 MANY_CACTUS, 4 BIG_CACTUS, 5-7 NOTHING.
- slot_pos  in  9*N_SLOTS  per-slot right edge x (exclusive).
- rom_addr  out  ADDR_W  registered atlas address.
- rom_data  in  12  atlas data; valid one pix_en tick after rom_addr.
- dino_opaque  in  1  dino pixel is opaque; time-aligned with pixel.
- collide_clr  in  1  clears collide.
- pixel  out  12  RGB444; 12'hFFF is background.
- pixel_hit  out  1  pixel comes from an obstacle box.
- collide  out  1  sticky collision flag.

## Operation
- Shadow registers: on frame_start, copy slot_en/type/pos into shadow registers. Rendering uses shadows only. Reset value of every shadow slot is disabled.
- Geometry per type (width x height, bottom y exclusive):
  - bird 44x33; LOW y=140, HIGH y=100.
  - small 19x36, many 77x49, big 27x50; all y=147.
- Box test is inclusive-left/exclusive-right: pos-w <= h < pos and y-hgt <= v < y.
- Left edge clamps at 0 when pos < w. Column is h+w-pos computed at 11 bits, so clipped sprites show their right part.
- Type NOTHING or a disabled slot never hits.
- Priority: the lowest-index hitting slot owns the pixel. Only one ROM read per pixel; overlapping boxes show only the front slot.
- Address: base(type, flap) + row*w + col, with row = v-(y-hgt).
  - Bases: bird0 0, bird1 1452, small 2904, many 3588, big 7361.
- Flap: a counter increments on each frame_start. When it reaches FLAP_FRAMES-1 it wraps to 0 and toggles flap. Reset: counter 0, flap 0.
- Collide: set when pixel_hit && pixel!=12'hFFF && dino_opaque at an output tick. Cleared by collide_clr. If set and clear happen in the same cycle, set wins. Reset value 0.

## Timing
- Stage A (pix_en tick t): box test, priority select, address. Registers rom_addr, hit, and a valid flag.
- Stage B (tick t+1): rom_data returns.
- Output (tick t+2): pixel <= hit ? rom_data : 12'hFFF, and pixel_hit <= hit.
- Latency is 2 pix_en ticks from h_cnt/v_cnt to pixel. Outputs hold between ticks.
- Reset values: rom_addr 0, pixel 12'hFFF, pixel_hit 0, collide 0.
- frame_start during active video: the new shadows take effect at the next stage-A tick. In-flight pixels complete with their captured hit and data.
- Reset asserted mid-frame: all state clears immediately. Output is background until the next frame_start loads slots.

## Structure
- Shared package dino_pkg holds: type codes, GROUND/LOW_SKY/HIGH_SKY, per-type width/height, and atlas base addresses.
- One natural sub-module, sprite_box_hit: per-slot box test plus row/col, instantiated N_SLOTS times.
- Priority select, address multiply-add, flap counter and collide flag live in the top module.

## Test plan
- Single small cactus, slot0 pos=100, after frame_start:
  - (h=81, v=111) -> rom_addr 2904, pixel_hit=1 two ticks later.
  - (99, 146) -> rom_addr 3587.
  - (100, 146) -> pixel 12'hFFF, pixel_hit=0.
- Big cactus pos=10, (h=0, v=97) -> rom_addr 7378 (col 17).
- Slot0 many-cactus pos=200 and slot1 big-cactus pos=190:
  - (h=180, v=140) -> address from slot0: 3588+42*77+57 = 6879.
- Change slot_pos mid-frame -> rendered position unchanged until the next frame_start.
- High bird pos=300, FLAP_FRAMES=12:
  - after 11 frame_starts, (256, 67) -> rom_addr 0.
  - after the 12th -> 1452.
- Collision and reset:
  - dino_opaque=1 over an opaque cactus pixel -> collide=1, held until collide_clr.
  - collide_clr together with a new hit -> collide stays 1.
  - rst low mid-frame -> collide 0, pixel 12'hFFF.
